// File: rtl/ex_hilo_ctrl_pkg.sv
// Shared definitions for the EX-stage HI/LO controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ex_hilo_ctrl_pkg;

    localparam logic [2:0] HILO_OP_NONE  = 3'd0;
    localparam logic [2:0] HILO_OP_MULT  = 3'd1;
    localparam logic [2:0] HILO_OP_MULTU = 3'd2;
    localparam logic [2:0] HILO_OP_DIV   = 3'd3;
    localparam logic [2:0] HILO_OP_DIVU  = 3'd4;
    localparam logic [2:0] HILO_OP_MTHI  = 3'd5;
    localparam logic [2:0] HILO_OP_MTLO  = 3'd6;

    localparam int DIV_STEPS = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } hilo_state_t;

    // Magnitude of a 32-bit value; 0x80000000 maps to itself, which is the
    // correct unsigned magnitude.
    function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/ex_div_iter.sv
// Restoring divider core: unsigned 32/32, one quotient bit per enabled cycle.
// Latency: DIV_STEPS enabled cycles after start; last_o flags the final step.
// Backpressure: none; steps only while en_i is high, start_i reloads at any time.
module ex_div_iter
    import ex_hilo_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic        en_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic [31:0] quotient_o,
    output logic [31:0] remainder_o,
    output logic        last_o
);

    logic [31:0] rem_q, quo_q, dvs_q;
    logic [4:0]  cnt_q;
    logic [32:0] shifted;
    logic        take;
    logic [31:0] rem_d, quo_d;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    // The running remainder is always below the divisor, so 32 bits hold it.
    always_comb begin
        shifted = {rem_q, quo_q[31]};
        take    = shifted[32] || (shifted[31:0] >= dvs_q);
        rem_d   = take ? (shifted[31:0] - dvs_q) : shifted[31:0];
        quo_d   = {quo_q[30:0], take};
    end

    // Shift registers: the quotient register starts out holding the dividend.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else if (start_i) begin
            rem_q <= '0;
            quo_q <= dividend_i;
            dvs_q <= divisor_i;
            cnt_q <= '0;
        end else if (en_i) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + 5'd1;
        end
    end

    // Results are the post-step values so the caller can capture them on the last edge.
    assign quotient_o  = quo_d;
    assign remainder_o = rem_d;
    assign last_o      = en_i && (cnt_q == 5'(DIV_STEPS - 1));

endmodule

// File: rtl/ex_hilo_ctrl.sv
// EX-stage HI/LO owner: sequences MULT/MULTU, DIV/DIVU and MTHI/MTLO.
// Latency: mul 1+MUL_CYCLES stall cycles, div 33, div-by-zero 1, MT none; then a one-cycle done.
// Backpressure: stall (combinational) holds IF/ID/EX while a mult/div runs; flush aborts.
module ex_hilo_ctrl
    import ex_hilo_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        stall,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    hilo_state_t state_q;
    logic [31:0] hi_q, lo_q;
    logic [63:0] prod_q;
    logic [3:0]  mul_cnt_q;
    logic        done_q;
    logic        qneg_q, rneg_q;

    logic        is_mul, is_div, is_sdiv, accept;
    logic [63:0] mul_a_ext, mul_b_ext, mul_prod;
    logic [31:0] div_quo, div_rem, quo_fix, rem_fix;
    logic        div_last;

    // Decode and accept; reset also blocks acceptance so stall drops at once.
    always_comb begin
        is_mul  = (op == HILO_OP_MULT) || (op == HILO_OP_MULTU);
        is_div  = (op == HILO_OP_DIV)  || (op == HILO_OP_DIVU);
        is_sdiv = (op == HILO_OP_DIV);
        accept  = rst_n && (state_q == ST_IDLE) && op_valid && !flush && (is_mul || is_div);
        stall   = accept || (state_q == ST_MUL) || (state_q == ST_DIV);
    end

    // 64-bit product: sign- or zero-extended operands, low 64 bits are exact for both.
    always_comb begin
        mul_a_ext = (op == HILO_OP_MULT) ? {{32{src_a[31]}}, src_a} : {32'd0, src_a};
        mul_b_ext = (op == HILO_OP_MULT) ? {{32{src_b[31]}}, src_b} : {32'd0, src_b};
        mul_prod  = mul_a_ext * mul_b_ext;
    end

    ex_div_iter u_div (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (accept && is_div),
        .en_i        (state_q == ST_DIV),
        .dividend_i  (abs32(src_a, is_sdiv)),
        .divisor_i   (abs32(src_b, is_sdiv)),
        .quotient_o  (div_quo),
        .remainder_o (div_rem),
        .last_o      (div_last)
    );

    // Sign fix applied at the write: quotient by sign(a)^sign(b), remainder by sign(a).
    always_comb begin
        quo_fix = qneg_q ? (~div_quo + 32'd1) : div_quo;
        rem_fix = rneg_q ? (~div_rem + 32'd1) : div_rem;
    end

    // Control FSM plus HI/LO registers; flush overrides everything else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            hi_q      <= '0;
            lo_q      <= '0;
            prod_q    <= '0;
            mul_cnt_q <= '0;
            done_q    <= 1'b0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (flush) begin
                state_q <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (accept && is_mul) begin
                            prod_q    <= mul_prod;
                            mul_cnt_q <= 4'(MUL_CYCLES - 1);
                            state_q   <= ST_MUL;
                        end else if (accept) begin
                            qneg_q <= is_sdiv && (src_a[31] ^ src_b[31]);
                            rneg_q <= is_sdiv && src_a[31];
                            if (src_b == 32'd0) begin
                                state_q <= ST_DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= ST_DIV;
                            end
                        end else if (op_valid && (op == HILO_OP_MTHI)) begin
                            hi_q <= src_a;
                        end else if (op_valid && (op == HILO_OP_MTLO)) begin
                            lo_q <= src_a;
                        end
                    end
                    ST_MUL: begin
                        if (mul_cnt_q == 4'd0) begin
                            {hi_q, lo_q} <= prod_q;
                            state_q      <= ST_DONE;
                            done_q       <= 1'b1;
                        end else begin
                            mul_cnt_q <= mul_cnt_q - 4'd1;
                        end
                    end
                    ST_DIV: begin
                        if (div_last) begin
                            lo_q    <= quo_fix;
                            hi_q    <= rem_fix;
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
